// File: rtl/apb4_tmr_mc.sv
// apb4_tmr_mc: multi-channel APB4 timer. One shared prescaler drives CH_NUM
// up/down counters with compare/reload, one-shot mode and overflow interrupts.
// Optional input capture is compiled in when TMR_CAP_EN is defined.
module apb4_tmr_mc #(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned PSCR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [CH_NUM-1:0] cap_i,
    output logic [CH_NUM-1:0] irq_o
);
    logic                         acc, glb, ch_ok, addr_err, wr;
    logic                         pscr_we, stat_we, tick;
    logic [3:0]                   blk, ch_idx;
    logic [1:0]                   reg_sel;
    logic [PSCR_W-1:0]            pscr, pc;
    logic [CH_NUM-1:0]            ovie_v, ov_v, ovif;
    logic [CH_NUM-1:0][5:0]       ctrl_v;
    logic [CH_NUM-1:0][CNT_W-1:0] cmp_v, cnt_v;
    logic [31:0]                  stat_rd;
    logic                         unused_ok;
`ifdef TMR_CAP_EN
    logic [CH_NUM-1:0]            cap_ev_v, capif;
    logic [CH_NUM-1:0][CNT_W-1:0] cap_v;
`endif

    // address decode: word index paddr[7:2], block 0 is global, block n+1 is channel n
    assign acc       = psel & penable;
    assign blk       = paddr[7:4];
    assign reg_sel   = paddr[3:2];
    assign glb       = (blk == 4'd0);
    assign ch_idx    = blk - 4'd1;
    assign ch_ok     = !glb && (32'(ch_idx) < CH_NUM);
    assign addr_err  = glb ? reg_sel[1] : (!ch_ok || (pwrite && (reg_sel == 2'd3)));
    assign pslverr   = acc & addr_err;
    assign wr        = acc & pwrite & ~addr_err;
    assign pscr_we   = wr & glb & (reg_sel == 2'd0);
    assign stat_we   = wr & glb & (reg_sel == 2'd1);
    assign pready    = 1'b1;
    assign unused_ok = ^{paddr[1:0], cap_i};

    assign tick = (pc == pscr);

    // shared prescaler; a PSCR write restarts the period
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pscr <= '0;
            pc   <= '0;
        end else if (pscr_we) begin
            pscr <= pwdata[PSCR_W-1:0];
            pc   <= '0;
        end else if (tick) begin
            pc <= '0;
        end else begin
            pc <= pc + PSCR_W'(1);
        end
    end

    for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
        logic             sel, ctrl_we, cmp_we, cnt_we, en_load, ov;
        logic             en, dir, oneshot, ovie;
        logic [1:0]       capedge;
        logic [CNT_W-1:0] cmp, cnt;

        assign sel     = wr & ch_ok & (ch_idx == 4'(n));
        assign ctrl_we = sel & (reg_sel == 2'd0);
        assign cmp_we  = sel & (reg_sel == 2'd1);
        assign cnt_we  = sel & (reg_sel == 2'd2);
        assign en_load = ctrl_we & pwdata[0] & ~en;
        assign ov      = en & tick & (dir ? (cnt == '0) : (cnt == cmp));

        // control and compare registers; one-shot overflow drops EN
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                en      <= 1'b0;
                dir     <= 1'b0;
                oneshot <= 1'b0;
                ovie    <= 1'b0;
                cmp     <= '0;
`ifdef TMR_CAP_EN
                capedge <= 2'b00;
`endif
            end else begin
                if (ctrl_we) begin
                    en      <= pwdata[0];
                    dir     <= pwdata[1];
                    oneshot <= pwdata[2];
                    ovie    <= pwdata[3];
`ifdef TMR_CAP_EN
                    capedge <= pwdata[5:4];
`endif
                end else if (ov && oneshot) begin
                    en <= 1'b0;
                end
                if (cmp_we) cmp <= pwdata[CNT_W-1:0];
            end
        end

        // counter: CNT write beats enable load, which beats a tick
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt <= '0;
            end else if (cnt_we) begin
                cnt <= pwdata[CNT_W-1:0];
            end else if (en_load) begin
                cnt <= pwdata[1] ? cmp : '0;
            end else if (en && tick) begin
                if (ov)       cnt <= dir ? cmp : '0;
                else if (dir) cnt <= cnt - CNT_W'(1);
                else          cnt <= cnt + CNT_W'(1);
            end
        end

`ifdef TMR_CAP_EN
        logic             s1, s2, dly, cap_ev;
        logic [CNT_W-1:0] cap;
        assign cap_ev = (capedge[0] & s2 & ~dly) | (capedge[1] & ~s2 & dly);

        // pin synchroniser, edge-detect delay stage and capture register
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                s1  <= 1'b0;
                s2  <= 1'b0;
                dly <= 1'b0;
                cap <= '0;
            end else begin
                s1  <= cap_i[n];
                s2  <= s1;
                dly <= s2;
                if (cap_ev) cap <= cnt;
            end
        end
        assign cap_ev_v[n] = cap_ev;
        assign cap_v[n]    = cap;
`else
        assign capedge = 2'b00;
`endif

        assign ctrl_v[n] = {capedge, ovie, oneshot, dir, en};
        assign cmp_v[n]  = cmp;
        assign cnt_v[n]  = cnt;
        assign ovie_v[n] = ovie;
        assign ov_v[n]   = ov;
    end

    // status flags: W1C, a hardware set in the same cycle wins
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovif <= '0;
`ifdef TMR_CAP_EN
            capif <= '0;
`endif
        end else begin
            ovif <= (ovif & ~(stat_we ? pwdata[CH_NUM-1:0] : '0)) | ov_v;
`ifdef TMR_CAP_EN
            capif <= (capif & ~(stat_we ? pwdata[8 +: CH_NUM] : '0)) | cap_ev_v;
`endif
        end
    end

`ifdef TMR_CAP_EN
    assign irq_o = (ovif | capif) & ovie_v;
`else
    assign irq_o = ovif & ovie_v;
`endif

    // STAT read image
    always_comb begin
        stat_rd = '0;
        stat_rd[CH_NUM-1:0] = ovif;
`ifdef TMR_CAP_EN
        stat_rd[8 +: CH_NUM] = capif;
`endif
    end

    // combinational read mux, zero outside a valid read access
    always_comb begin
        prdata = '0;
        if (acc && !pwrite && !addr_err) begin
            if (glb) begin
                prdata = reg_sel[0] ? stat_rd : 32'(pscr);
            end else begin
                for (int n = 0; n < CH_NUM; n++) begin
                    if (ch_idx == 4'(n)) begin
                        case (reg_sel)
                            2'd0:    prdata = 32'(ctrl_v[n]);
                            2'd1:    prdata = 32'(cmp_v[n]);
                            2'd2:    prdata = 32'(cnt_v[n]);
`ifdef TMR_CAP_EN
                            default: prdata = 32'(cap_v[n]);
`else
                            default: prdata = '0;
`endif
                        endcase
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_apb4_tmr_mc.sv
// Self-checking bench for apb4_tmr_mc (default parameters).
module tb_apb4_tmr_mc;
    localparam int unsigned CH_NUM = 4;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned PSCR_W = 16;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [7:0]        paddr;
    logic              psel, penable, pwrite;
    logic [31:0]       pwdata, prdata;
    logic              pready, pslverr;
    logic [CH_NUM-1:0] cap_i, irq_o;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    exp_t        sb[$];

    apb4_tmr_mc #(.CH_NUM(CH_NUM), .CNT_W(CNT_W), .PSCR_W(PSCR_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .cap_i(cap_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // idle until the next read would sample the state after edge 'target'
    task automatic idle_to(input int unsigned target);
        while (cyc + 1 < target) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(posedge clk_i); #1 penable = 1'b1;
        @(negedge clk_i); err = pslverr;
        @(posedge clk_i); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        logic e;
        apb_write(a, d, e);
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(posedge clk_i); #1 penable = 1'b1;
        @(negedge clk_i); d = prdata; err = pslverr;
        @(posedge clk_i); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er; exp_t e;
        logic [7:0] addrs[$] = '{8'h00, 8'h04, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h48};
        checks++;
        if (irq_o !== '0 || pslverr !== 1'b0 || prdata !== 32'h0 || pready !== 1'b1) begin
            failures++;
            $display("FAIL reset_outputs: got irq=%h err=%b prdata=%h pready=%b want 0/0/0/1",
                     irq_o, pslverr, prdata, pready);
        end
        foreach (addrs[i]) begin
            sb.push_back('{data: 32'h0, err: 1'b0});
            apb_read(addrs[i], rd, er);
            e = sb.pop_front();
            checks++;
            if (rd !== e.data || er !== e.err) begin
                failures++;
                $display("FAIL reset_reg[%h]: got %h/%b want %h/%b", addrs[i], rd, er, e.data, e.err);
            end
        end
    endtask

    int unsigned w0;

    task automatic test_up_periodic();
        logic [31:0] rd; logic er; exp_t e; int unsigned s;
        wr_reg(8'h00, 32'd0);
        wr_reg(8'h14, 32'd3);
        wr_reg(8'h10, 32'h9);
        w0 = cyc;
        repeat (4) @(negedge clk_i);
        checks++;
        if (irq_o[0] !== 1'b0) begin
            failures++; $display("FAIL up_irq_early: got %b want 0", irq_o[0]);
        end
        @(negedge clk_i);
        checks++;
        if (irq_o[0] !== 1'b1) begin
            failures++; $display("FAIL up_irq_rise: got %b want 1", irq_o[0]);
        end
        @(posedge clk_i); #1;
        for (int i = 0; i < 6; i++) begin
            s = cyc + 1 + $urandom_range(0, 2);
            sb.push_back('{data: 32'((s - w0) % 4), err: 1'b0});
            idle_to(s);
            apb_read(8'h18, rd, er);
            e = sb.pop_front();
            checks++;
            if (rd !== e.data || er !== e.err) begin
                failures++; $display("FAIL up_cnt@%0d: got %h want %h", s - w0, rd, e.data);
            end
        end
        while ((cyc + 2 - w0) % 4 != 1) begin @(posedge clk_i); #1; end
        wr_reg(8'h04, 32'h1);
        @(negedge clk_i);
        checks++;
        if (irq_o[0] !== 1'b0) begin
            failures++; $display("FAIL up_w1c: irq got %b want 0", irq_o[0]);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_collisions();
        logic [31:0] rd; logic er; exp_t e; int unsigned p, x;
        while ((cyc + 2 - w0) % 4 != 0) begin @(posedge clk_i); #1; end
        wr_reg(8'h04, 32'h1);
        @(negedge clk_i);
        checks++;
        if (irq_o[0] !== 1'b1) begin
            failures++; $display("FAIL coll_ovif: irq got %b want 1", irq_o[0]);
        end
        @(posedge clk_i); #1;
        wr_reg(8'h10, 32'h0);
        wr_reg(8'h04, 32'hFFFF_FFFF);
        wr_reg(8'h00, 32'd3);
        p = cyc;
        wr_reg(8'h34, 32'hFF);
        wr_reg(8'h30, 32'h1);
        while ((cyc + 2 - p) % 4 != 0) begin @(posedge clk_i); #1; end
        wr_reg(8'h38, 32'h10);
        x = cyc;
        sb.push_back('{data: 32'h10, err: 1'b0});
        sb.push_back('{data: 32'h11, err: 1'b0});
        for (int i = 0; i < 2; i++) begin
            idle_to(x + ((i == 0) ? 1 : 4));
            apb_read(8'h38, rd, er);
            e = sb.pop_front();
            checks++;
            if (rd !== e.data || er !== e.err) begin
                failures++; $display("FAIL coll_cnt_wr[%0d]: got %h want %h", i, rd, e.data);
            end
        end
        wr_reg(8'h30, 32'h0);
    endtask

    task automatic test_down_oneshot();
        logic [31:0] rd; logic er; exp_t e; int unsigned p, w;
        logic [7:0]  addrs[$] = '{8'h28, 8'h04, 8'h28, 8'h04, 8'h20, 8'h28};
        int unsigned offs[$]  = '{4, 17, 19, 21, 23, 30};
        logic [31:0] vals[$]  = '{32'd4, 32'h0, 32'd5, 32'h2, 32'h6, 32'd5};
        wr_reg(8'h00, 32'd2);
        p = cyc;
        wr_reg(8'h24, 32'd5);
        while ((cyc + 2 - p) % 3 != 0) begin @(posedge clk_i); #1; end
        wr_reg(8'h20, 32'h7);
        w = cyc;
        foreach (addrs[i]) begin
            sb.push_back('{data: vals[i], err: 1'b0});
            idle_to(w + offs[i]);
            apb_read(addrs[i], rd, er);
            e = sb.pop_front();
            checks++;
            if (rd !== e.data || er !== e.err) begin
                failures++;
                $display("FAIL down_os[%h]@%0d: got %h want %h", addrs[i], offs[i], rd, e.data);
            end
        end
        checks++;
        if (irq_o !== '0) begin
            failures++; $display("FAIL down_os_irq: got %h want 0", irq_o);
        end
    endtask

    task automatic test_channels();
        logic [31:0] rd; logic er; exp_t e; int unsigned s, n;
        int unsigned wn[CH_NUM];
        wr_reg(8'h00, 32'd0);
        for (int c = 0; c < CH_NUM; c++) wr_reg(8'(8'h14 + 16 * c), 32'(c + 1));
        for (int c = 0; c < CH_NUM; c++) begin
            wr_reg(8'(8'h10 + 16 * c), 32'h9);
            wn[c] = cyc;
        end
        for (int i = 0; i < 12; i++) begin
            n = i % CH_NUM;
            s = cyc + 1 + $urandom_range(0, 1);
            sb.push_back('{data: 32'((s - wn[n]) % (n + 2)), err: 1'b0});
            idle_to(s);
            apb_read(8'(8'h18 + 16 * n), rd, er);
            e = sb.pop_front();
            checks++;
            if (rd !== e.data || er !== e.err) begin
                failures++; $display("FAIL chan%0d_cnt: got %h want %h", n, rd, e.data);
            end
        end
        checks++;
        if (irq_o !== 4'hF) begin
            failures++; $display("FAIL chan_irq: got %h want f", irq_o);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; exp_t e;
        logic [7:0]  addrs[$] = '{8'h50, 8'h08, 8'h0C, 8'hF0, 8'h1C};
        logic        errs[$]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0]  waddr[$] = '{8'h1C, 8'h50, 8'h08};
        foreach (addrs[i]) begin
            sb.push_back('{data: 32'h0, err: errs[i]});
            apb_read(addrs[i], rd, er);
            e = sb.pop_front();
            checks++;
            if (rd !== e.data || er !== e.err) begin
                failures++;
                $display("FAIL err_rd[%h]: got %h/%b want %h/%b", addrs[i], rd, er, e.data, e.err);
            end
        end
        foreach (waddr[i]) begin
            apb_write(waddr[i], 32'h5, er);
            checks++;
            if (er !== 1'b1) begin
                failures++; $display("FAIL err_wr[%h]: pslverr got %b want 1", waddr[i], er);
            end
        end
        apb_read(8'h00, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            failures++; $display("FAIL err_wr_ignored: PSCR got %h/%b want 0/0", rd, er);
        end
    endtask

`ifdef TMR_CAP_EN
    task automatic test_capture();
        logic [31:0] rd; logic er; exp_t e; int unsigned w, k;
        wr_reg(8'h30, 32'h0);
        wr_reg(8'h34, 32'hFFFF);
        wr_reg(8'h30, 32'h11);
        w = cyc;
        repeat (3) @(posedge clk_i);
        #1 cap_i[2] = 1'b1;
        k = cyc + 1;
        sb.push_back('{data: 32'(k + 1 - w), err: 1'b0});
        idle_to(k + 4);
        apb_read(8'h3C, rd, er);
        e = sb.pop_front();
        checks++;
        if (rd !== e.data || er !== e.err) begin
            failures++; $display("FAIL cap_value: got %h want %h", rd, e.data);
        end
        apb_read(8'h04, rd, er);
        checks++;
        if ((rd & 32'h400) !== 32'h400) begin
            failures++; $display("FAIL cap_flag: STAT got %h want bit10 set", rd);
        end
        wr_reg(8'h04, 32'h400);
        cap_i[2] = 1'b0;
        repeat (8) @(posedge clk_i);
        #1;
        apb_read(8'h04, rd, er);
        checks++;
        if ((rd & 32'h400) !== 32'h0) begin
            failures++; $display("FAIL cap_fall: STAT got %h want bit10 clear", rd);
        end
        sb.push_back('{data: 32'(k + 1 - w), err: 1'b0});
        apb_read(8'h3C, rd, er);
        e = sb.pop_front();
        checks++;
        if (rd !== e.data || er !== e.err) begin
            failures++; $display("FAIL cap_hold: got %h want %h", rd, e.data);
        end
    endtask
`else
    task automatic test_capture();
        logic [31:0] rd; logic er;
        wr_reg(8'h30, 32'h30);
        cap_i = '1;
        repeat (6) @(posedge clk_i);
        #1;
        apb_read(8'h30, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            failures++; $display("FAIL nocap_ctrl: got %h/%b want 0/0", rd, er);
        end
        apb_read(8'h04, rd, er);
        checks++;
        if ((rd & 32'hFF00) !== 32'h0) begin
            failures++; $display("FAIL nocap_stat: got %h want bits 15:8 zero", rd);
        end
        apb_read(8'h3C, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            failures++; $display("FAIL nocap_cap: got %h/%b want 0/0", rd, er);
        end
        cap_i = '0;
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; exp_t e;
        logic [7:0] addrs[$] = '{8'h00, 8'h04, 8'h10, 8'h14, 8'h18, 8'h40, 8'h48, 8'h18};
        @(posedge clk_i); #1 rst_i = 1'b1;
        @(posedge clk_i); #1 rst_i = 1'b0;
        checks++;
        if (irq_o !== '0) begin
            failures++; $display("FAIL rst_mid_irq: got %h want 0", irq_o);
        end
        foreach (addrs[i]) begin
            sb.push_back('{data: 32'h0, err: 1'b0});
            apb_read(addrs[i], rd, er);
            e = sb.pop_front();
            checks++;
            if (rd !== e.data || er !== e.err) begin
                failures++; $display("FAIL rst_mid[%h]: got %h want %h", addrs[i], rd, e.data);
            end
        end
    endtask

    initial begin
        rst_i = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; cap_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        test_reset();
        test_up_periodic();
        test_collisions();
        test_down_oneshot();
        test_channels();
        test_errors();
        test_capture();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb4_tmr_mc.md
# apb4_tmr_mc

Multi-channel APB4 timer: one shared prescaler drives `CH_NUM` independent counters. Each counter counts up or down against its own compare/reload value, in periodic or one-shot mode, and raises a per-channel overflow interrupt. Optional per-channel input capture latches the running count on a selected edge of an external pin. The block sits on the peripheral APB4 bus beside the single-channel timer. It runs entirely on one clock, so there are no divided clocks and no internal CDC.

## Interface
- `CH_NUM`, 4: channel count, legal range 1..8.
- `CNT_W`, 32: counter, compare and capture width, legal range 8..32.
- `PSCR_W`, 16: prescaler width, legal range 1..32.

- `clk_i` in 1: APB clock (pclk); the only clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `paddr` in 8: byte address; only `paddr[7:2]` is decoded.
- `psel`, `penable`, `pwrite` in 1 each: APB4 control.
- `pwdata` in 32: write data.
- `prdata` out 32: read data.
- `pready` out 1: tied to 1.
- `pslverr` out 1: access error flag.
- `cap_i` in `CH_NUM`: asynchronous capture pins.
- `irq_o` out `CH_NUM`: per-channel level interrupt.

## Operation
- **Access phase:** `psel & penable`. Writes take effect at the clock edge that ends the access phase. Reads are combinational during the access phase; `prdata` is 0 outside it.
- **Global registers:**
  - 0x00 PSCR: prescaler reload value.
  - 0x04 STAT: OVIF at bit n, CAPIF at bit 8+n. Write-1-to-clear.
- **Per-channel registers**, base 0x10+0x10·n:
  - +0 CTRL: [0] EN, [1] DIR (0=up), [2] ONESHOT, [3] OVIE, [5:4] CAPEDGE (00 off, 01 rise, 10 fall, 11 both).
  - +4 CMP.
  - +8 CNT, read/write.
  - +C CAP, read-only.
- **`pslverr`:** 1 in the access phase for an unmapped address, a channel index ≥ `CH_NUM`, or a write to CAP. Such writes are ignored and such reads return 0.
- **Prescaler:** counter `pc` produces `tick`=1 when `pc==PSCR`, then `pc` wraps to 0.
  - PSCR=0 gives a tick every cycle.
  - Any PSCR write forces `pc` to 0.
- **Enable load:** on a CTRL write that sets EN from 0 to 1, CNT loads 0 if DIR=0, or CMP if DIR=1. This load takes priority over a tick in the same cycle.
- **Counting:** only when EN=1 and `tick`=1.
  - Up mode: CNT==CMP → CNT=0 and overflow; otherwise CNT+1.
  - Down mode: CNT==0 → CNT=CMP and overflow; otherwise CNT−1.
  - Up mode with CNT>CMP (after a CNT/CMP write): the counter runs up to 2^CNT_W−1, wraps to 0 with no overflow, then continues normally.
- **Overflow:** sets OVIF[n] regardless of OVIE. If ONESHOT=1, EN clears in the same edge and CNT holds the reload value.
- **`irq_o[n]`** = OVIF[n] & OVIE[n] (| CAPIF[n] & OVIE[n] when capture is compiled in).
- **CNT write:** overrides any count/reload in the same cycle.
- **STAT set vs clear:** if a hardware set and a W1C clear of the same bit coincide, the set wins.
- **CMP write:** takes effect at the next compare. No shadowing.
- **Reset:** all registers 0, `pc`=0, `prdata`=0, `irq_o`=0, `pslverr`=0. Reset has priority over everything and aborts counting mid-period.

## Timing
- A register write is visible to reads and to counting from the next cycle.
- Overflow tick at edge k: CNT reloaded at k; OVIF and `irq_o` high after k.
- PSCR=P gives exactly P+1 clocks between ticks.
- **Capture path:** `cap_i` → 2-FF synchroniser → 1 delay stage → edge detect.
  - An edge first sampled at edge k loads CAP at edge k+2, and CAPIF is visible after k+2.
  - CAP receives the CNT value held before edge k+2.
  - A capture with CAPIF already set overwrites CAP; CAPIF stays 1.

## Configuration
- **`TMR_CAP_EN` defined:** capture logic, CAP registers, CAPEDGE and CAPIF are implemented as above.
- **`TMR_CAP_EN` undefined:**
  - No synchronisers or CAP flops; `cap_i` is ignored.
  - CAP reads 0 with `pslverr`=0.
  - CAPEDGE is not writable and reads 0.
  - STAT[15:8] read 0.
  - `irq_o` is overflow-only.

## Test plan
- **Up, periodic:** PSCR=0, CH0 CMP=3, CTRL=0x9 → CNT sequence 0,1,2,3,0 and OVIF[0]/`irq_o[0]` rise after the 4th tick. W1C STAT=0x1 → `irq_o[0]` falls next cycle.
- **Down, one-shot:** PSCR=2, CH1 CMP=5, CTRL=0x7 → CNT decrements every 3 clocks, overflow after 18 clocks, EN reads 0, CNT holds 5.
- **Collisions:** W1C of OVIF in the same cycle as a new overflow → OVIF stays 1. CNT write of 0x10 on a tick cycle → CNT reads 0x10.
- **Channel independence:** 4 channels with CMP 1,2,3,4 → overflow periods of 2,3,4,5 ticks. Access to 0x50 → `pslverr`=1, `prdata`=0.
- **Capture (`TMR_CAP_EN`):** CAPEDGE=01, CNT counting; `cap_i[2]` rises → CAP[2] equals the CNT value 3 cycles later (allowing for the sync offset) and CAPIF[2] is set. A falling edge → no capture.
- **Reset mid-operation:** assert `rst_i` during count → next cycle all registers read 0 and `irq_o`=0.
